// File: rtl/usr_pkg.sv
// usr_pkg: shared definitions for the universal shift register.
//   - MODE_* : 3-bit operation codes selected on the mode port
//   - WIDTH_MIN / WIDTH_MAX : legal range of the register width
package usr_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_INC  = 3'b110;
   localparam logic [2:0] MODE_DEC  = 3'b111;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/dff_cell.sv
// dff_cell: one-bit rising-edge storage flop with synchronous reset.
// Ports:
//   clk     in  rising-edge clock
//   rst     in  synchronous reset, active-high
//   rst_val in  value captured when rst=1
//   d       in  next-state data
//   q       out stored bit
//   nq      out complement of q
module dff_cell (
   input  logic clk,
   input  logic rst,
   input  logic rst_val,
   input  logic d,
   output logic q,
   output logic nq
);

   always_ff @(posedge clk) begin
      if (rst) q <= rst_val;
      else     q <= d;
   end

   // Derived from q rather than stored separately, so nq can never equal q.
   assign nq = ~q;

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised N-bit register with hold / load / shift /
// rotate / up-count / down-count modes, clock enable and synchronous reset.
// Ports:
//   clk     in  rising-edge clock
//   rst     in  synchronous reset, active-high (highest priority)
//   en      in  clock enable; 0 holds Q regardless of mode
//   mode    in  [2:0] operation select (usr_pkg::MODE_*)
//   D       in  [WIDTH-1:0] parallel load data
//   sin_r   in  serial input into Q[0] on SHL
//   sin_l   in  serial input into Q[WIDTH-1] on SHR
//   Q       out [WIDTH-1:0] register contents
//   nQ      out [WIDTH-1:0] ~Q
//   sout_l  out Q[WIDTH-1]
//   sout_r  out Q[0]
//   tc      out terminal count: next enabled INC/DEC edge wraps
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] D,
   input  logic             sin_r,
   input  logic             sin_l,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] nQ,
   output logic             sout_l,
   output logic             sout_r,
   output logic             tc
);

   generate
      if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
         $error("univ_shift_reg: WIDTH must be within 2..32");
      end
   endgenerate

   logic [WIDTH-1:0] q_cur;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] q_inc;
   logic [WIDTH-1:0] q_dec;

   // Unsigned, WIDTH-bit wide: overflow simply wraps.
   assign q_inc = q_cur + 1'b1;
   assign q_dec = q_cur - 1'b1;

   // Next-state selection. en=0 (or HOLD) keeps the current value; reset
   // priority is applied inside each cell.
   always_comb begin
      q_next = q_cur;
      if (en) begin
         case (mode)
            MODE_HOLD: q_next = q_cur;
            MODE_LOAD: q_next = D;
            MODE_SHL:  q_next = {q_cur[WIDTH-2:0], sin_r};
            MODE_SHR:  q_next = {sin_l, q_cur[WIDTH-1:1]};
            MODE_ROL:  q_next = {q_cur[WIDTH-2:0], q_cur[WIDTH-1]};
            MODE_ROR:  q_next = {q_cur[0], q_cur[WIDTH-1:1]};
            MODE_INC:  q_next = q_inc;
            MODE_DEC:  q_next = q_dec;
            default:   q_next = q_cur;
         endcase
      end
   end

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         dff_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RST_VAL[i]),
            .d       (q_next[i]),
            .q       (q_cur[i]),
            .nq      (nQ[i])
         );
      end
   endgenerate

   assign Q      = q_cur;
   assign sout_l = q_cur[WIDTH-1];
   assign sout_r = q_cur[0];

   // Flags the edge on which a count would wrap; masked by rst since that
   // edge will reset instead of wrapping.
   assign tc = ~rst & en & (((mode == MODE_INC) & (&q_cur)) |
                            ((mode == MODE_DEC) & ~(|q_cur)));

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed-vector bench for univ_shift_reg (WIDTH=8).
// dut   : RST_VAL=8'h00, main instance and head of the cascade
// dut_r : RST_VAL=8'h81, shares every input with dut
// dut_b : RST_VAL=8'h00, tail of the cascade (sin_r <= dut.sout_l)
module tb_univ_shift_reg;
   import usr_pkg::*;

   localparam int W = 8;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst   = 1'b1;
   logic         en    = 1'b0;
   logic [2:0]   mode  = MODE_HOLD;
   logic [W-1:0] d     = '0;
   logic         sin_r = 1'b0;
   logic         sin_l = 1'b0;

   logic         b_en    = 1'b0;
   logic [2:0]   b_mode  = MODE_HOLD;
   logic [W-1:0] b_d     = '0;
   logic         b_sin_l = 1'b0;

   logic [W-1:0] q, nq, q_r, nq_r, q_b, nq_b;
   logic         sout_l, sout_r, tc;
   logic         sout_l_r, sout_r_r, tc_r;
   logic         sout_l_b, sout_r_b, tc_b;

   univ_shift_reg #(.WIDTH(W), .RST_VAL(8'h00)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .D(d),
      .sin_r(sin_r), .sin_l(sin_l),
      .Q(q), .nQ(nq), .sout_l(sout_l), .sout_r(sout_r), .tc(tc)
   );

   univ_shift_reg #(.WIDTH(W), .RST_VAL(8'h81)) dut_r (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .D(d),
      .sin_r(sin_r), .sin_l(sin_l),
      .Q(q_r), .nQ(nq_r), .sout_l(sout_l_r), .sout_r(sout_r_r), .tc(tc_r)
   );

   univ_shift_reg #(.WIDTH(W), .RST_VAL(8'h00)) dut_b (
      .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .D(b_d),
      .sin_r(sout_l), .sin_l(b_sin_l),
      .Q(q_b), .nQ(nq_b), .sout_l(sout_l_b), .sout_r(sout_r_b), .tc(tc_b)
   );

   // scoreboard counters
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one edge, then settle away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic [2:0] m, input logic [W-1:0] dv);
      en   = e;
      mode = m;
      d    = dv;
   endtask

   initial begin
      // 1. reset then load
      #1;
      rst = 1'b1; drive(1'b1, MODE_LOAD, 8'hEE);
      step();
      check("rst_q", q, 8'h00);
      check("rst_nq", nq, 8'hFF);
      check("rst_q_r", q_r, 8'h81);
      check("rst_nq_r", nq_r, 8'h7E);
      rst = 1'b0; drive(1'b1, MODE_LOAD, 8'hA5);
      step();
      check("load_q", q, 8'hA5);
      check("load_nq", nq, 8'h5A);
      check("load_sout_l", sout_l, 1'b1);
      check("load_sout_r", sout_r, 1'b1);
      drive(1'b1, MODE_HOLD, 8'h00);
      step();
      check("hold_en", q, 8'hA5);

      // 2. shifts and rotates
      drive(1'b1, MODE_SHL, 8'h00); sin_r = 1'b1;
      step();
      check("shl", q, 8'h4B);
      drive(1'b1, MODE_SHR, 8'h00); sin_l = 1'b0;
      step();
      check("shr", q, 8'h25);
      drive(1'b1, MODE_ROL, 8'h00);
      step();
      check("rol1", q, 8'h4A);
      for (int i = 1; i < 8; i++) step();
      check("rol8", q, 8'h25);
      drive(1'b1, MODE_ROR, 8'h00);
      step();
      check("ror", q, 8'h92);
      check("ror_sout_l", sout_l, 1'b1);
      check("ror_sout_r", sout_r, 1'b0);
      drive(1'b1, MODE_SHR, 8'h00); sin_l = 1'b1;
      step();
      check("shr_sin1", q, 8'hC9);

      // 3. count wrap and tc
      drive(1'b1, MODE_LOAD, 8'hFE);
      step();
      drive(1'b1, MODE_INC, 8'h00);
      #1;
      check("inc_tc0", tc, 1'b0);
      step();
      check("inc_ff", q, 8'hFF);
      check("inc_tc1", tc, 1'b1);
      step();
      check("inc_wrap", q, 8'h00);
      check("inc_tc_after", tc, 1'b0);
      drive(1'b1, MODE_DEC, 8'h00);
      #1;
      check("dec_tc1", tc, 1'b1);
      step();
      check("dec_wrap", q, 8'hFF);
      check("dec_tc_after", tc, 1'b0);
      step();
      check("dec_fe", q, 8'hFE);

      // 4. en=0 holds in every mode
      drive(1'b1, MODE_LOAD, 8'h3C);
      step();
      for (int m = 1; m < 8; m++) begin
         drive(1'b0, 3'(m), 8'hFF);
         sin_r = 1'b1; sin_l = 1'b1;
         #1;
         check($sformatf("en0_tc_m%0d", m), tc, 1'b0);
         step();
         check($sformatf("en0_q_m%0d", m), q, 8'h3C);
      end

      // 5. reset aborts a count
      drive(1'b1, MODE_LOAD, 8'h05);
      step();
      drive(1'b1, MODE_INC, 8'h00);
      step();
      step();
      check("inc_07", q, 8'h07);
      check("inc_07_r", q_r, 8'h07);
      rst = 1'b1;
      step();
      check("midrst_q", q, 8'h00);
      check("midrst_q_r", q_r, 8'h81);
      check("midrst_nq_r", nq_r, 8'h7E);
      rst = 1'b0; drive(1'b1, MODE_LOAD, 8'hFF);
      step();
      drive(1'b1, MODE_INC, 8'h00);
      #1;
      check("tc_pre_rst", tc, 1'b1);
      rst = 1'b1;
      #1;
      check("tc_rst_mask", tc, 1'b0);
      step();
      check("tc_rst_q", q, 8'h00);
      rst = 1'b0;

      // 6. cascade A.sout_l -> B.sin_r
      drive(1'b1, MODE_LOAD, 8'h80);
      b_en = 1'b1; b_mode = MODE_LOAD; b_d = 8'h00;
      step();
      drive(1'b1, MODE_SHL, 8'h00); sin_r = 1'b0;
      b_mode = MODE_SHL;
      step();
      check("chain_a", q, 8'h00);
      check("chain_b", q_b, 8'h01);
      step();
      check("chain_b2", q_b, 8'h02);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
